// File: rtl/arb21_pkg.sv
// rtl/arb21_pkg.sv - shared types and constants for the arb21_8 round-robin arbiter
// Purpose: arbiter FSM state encoding, mux select constants and the owner type
//          recorded by the round-robin "last" pointer.
// Ports:   none (package).
package arb21_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // mux21_8 select polarity: 1 steers requester A, 0 steers requester B.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

// File: rtl/mux21_8.sv
// rtl/mux21_8.sv - 8-bit 2:1 datapath mux built from NAND gates
// Purpose: steers data_a or data_b to the output.
// Ports:   sel  in  1  select, 1 = a, 0 = b
//          a    in  8  input selected when sel = 1
//          b    in  8  input selected when sel = 0
//          y    out 8  selected data (purely combinational)
module mux21_8 (
  input  logic       sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic       sel_n;
  logic [7:0] nand_a;
  logic [7:0] nand_b;

  // y = ~(~(a & sel) & ~(b & ~sel)): inverter plus two NAND levels per bit.
  assign sel_n  = ~sel;
  assign nand_a = ~(a & {8{sel}});
  assign nand_b = ~(b & {8{sel_n}});
  assign y      = ~(nand_a & nand_b);

endmodule

// File: rtl/arb21_8.sv
// rtl/arb21_8.sv - two-requester round-robin arbiter driving a shared mux21_8 datapath
// Purpose: grants the single 8-bit output path to requester A or B, owns the mux
//          select, forwards a valid/ready handshake to the downstream consumer.
//          Optional macro ARB21_BURST_LIMIT_EN adds a per-grant beat counter that
//          forces release after MAX_BURST transfers; without it ownership ends
//          only when the owner drops its request.
// Ports:   clk        in  1  clock, rising edge
//          rst_n      in  1  asynchronous active-low reset
//          req_a      in  1  requester A has a beat
//          data_a     in  8  requester A beat data
//          req_b      in  1  requester B has a beat
//          data_b     in  8  requester B beat data
//          gnt_a      out 1  A owns the datapath
//          gnt_b      out 1  B owns the datapath
//          out_data   out 8  muxed beat data
//          out_valid  out 1  out_data holds a valid beat
//          out_ready  in  1  downstream accepts the beat this cycle
//          sel        out 1  registered mux select, 1 = A, 0 = B
module arb21_8
  import arb21_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sel
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("arb21_8: MAX_BURST must be within 1..255");
  end

  arb_state_t state_q, state_d;
  owner_t     last_q, last_d;
  logic       sel_q, sel_d;
  logic       last_beat;

  assign gnt_a     = (state_q == OWN_A);
  assign gnt_b     = (state_q == OWN_B);
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign sel       = sel_q;

`ifdef ARB21_BURST_LIMIT_EN
  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic          xfer;
  logic [CW-1:0] cnt_q, cnt_d;

  assign xfer      = out_valid & out_ready;
  assign last_beat = xfer && (cnt_q == LAST_BEAT);

  // Any ownership change restarts the count, so the last beat of a burst
  // returns cnt to 0 instead of stepping past MAX_BURST-1.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign last_beat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the path last goes first.
        if (req_a && (!req_b || last_q == OWNER_B)) begin
          state_d = OWN_A;
          sel_d   = SEL_A;
        end else if (req_b) begin
          state_d = OWN_B;
          sel_d   = SEL_B;
        end
      end
      OWN_A: begin
        if (!req_a || last_beat) begin
          last_d = OWNER_A;
          if (req_b) begin
            state_d = OWN_B;
            sel_d   = SEL_B;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN_B: begin
        if (!req_b || last_beat) begin
          last_d = OWNER_B;
          if (req_a) begin
            state_d = OWN_A;
            sel_d   = SEL_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= OWNER_B;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  mux21_8 u_mux (
    .sel (sel_q),
    .a   (data_a),
    .b   (data_b),
    .y   (out_data)
  );

endmodule
